// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises instruction (a) and data (b) port requests onto one pmem interface.
// Each transaction's controls are latched at grant; read data is registered before the response pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read_a,
  input  logic                    mem_write_a,
  input  logic [DATA_WIDTH/8-1:0] mem_wmask_a,
  input  logic [ADDR_WIDTH-1:0]   mem_address_a,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_a,
  output logic                    mem_resp_a,
  output logic [DATA_WIDTH-1:0]   mem_rdata_a,
  input  logic                    mem_read_b,
  input  logic                    mem_write_b,
  input  logic [DATA_WIDTH/8-1:0] mem_wmask_b,
  input  logic [ADDR_WIDTH-1:0]   mem_address_b,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_b,
  output logic                    mem_resp_b,
  output logic [DATA_WIDTH-1:0]   mem_rdata_b,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic                    pmem_resp,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_A = 3'd1;
  localparam logic [2:0] BUSY_B = 3'd2;
  localparam logic [2:0] DONE_A = 3'd3;
  localparam logic [2:0] DONE_B = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_next_s;
  logic                  last_grant_r;  // 1'b0 = port a, 1'b1 = port b
  logic                  req_a_s;
  logic                  req_b_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  busy_s;
  logic                  op_write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [MASK_WIDTH-1:0] wmask_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_a_r;
  logic [DATA_WIDTH-1:0] rdata_b_r;

  assign req_a_s = mem_read_a | mem_write_a;
  assign req_b_s = mem_read_b | mem_write_b;

  // Next-state and grant decode; on contention the port not granted last wins
  always_comb begin
    state_next_s = state_r;
    grant_a_s    = 1'b0;
    grant_b_s    = 1'b0;
    case (state_r)
      IDLE: begin
        grant_a_s = req_a_s & (~req_b_s | last_grant_r);
        grant_b_s = req_b_s & (~req_a_s | ~last_grant_r);
        if (grant_a_s) begin
          state_next_s = BUSY_A;
        end else if (grant_b_s) begin
          state_next_s = BUSY_B;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_A: begin
        if (pmem_resp) begin
          state_next_s = DONE_A;
        end else begin
          state_next_s = BUSY_A;
        end
      end
      BUSY_B: begin
        if (pmem_resp) begin
          state_next_s = DONE_B;
        end else begin
          state_next_s = BUSY_B;
        end
      end
      DONE_A:  state_next_s = IDLE;
      DONE_B:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (grant_a_s) begin
        last_grant_r <= 1'b0;
      end else if (grant_b_s) begin
        last_grant_r <= 1'b1;
      end
    end
  end

  // Transaction latch at grant; a write strobe takes priority over a read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_r <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wmask_r    <= {MASK_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
    end else if (grant_a_s) begin
      op_write_r <= mem_write_a;
      addr_r     <= mem_address_a;
      wmask_r    <= mem_wmask_a;
      wdata_r    <= mem_wdata_a;
    end else if (grant_b_s) begin
      op_write_r <= mem_write_b;
      addr_r     <= mem_address_b;
      wmask_r    <= mem_wmask_b;
      wdata_r    <= mem_wdata_b;
    end
  end

  // Read data capture; held until the same port's next read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_r <= {DATA_WIDTH{1'b0}};
      rdata_b_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (state_r == BUSY_A && pmem_resp && !op_write_r) begin
        rdata_a_r <= pmem_rdata;
      end
      if (state_r == BUSY_B && pmem_resp && !op_write_r) begin
        rdata_b_r <= pmem_rdata;
      end
    end
  end

  assign busy_s       = (state_r == BUSY_A) || (state_r == BUSY_B);
  assign pmem_read    = busy_s & ~op_write_r;
  assign pmem_write   = busy_s & op_write_r;
  assign pmem_address = busy_s ? addr_r  : {ADDR_WIDTH{1'b0}};
  assign pmem_wmask   = busy_s ? wmask_r : {MASK_WIDTH{1'b0}};
  assign pmem_wdata   = busy_s ? wdata_r : {DATA_WIDTH{1'b0}};
  assign mem_resp_a   = (state_r == DONE_A);
  assign mem_resp_b   = (state_r == DONE_B);
  assign mem_rdata_a  = rdata_a_r;
  assign mem_rdata_b  = rdata_b_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory responder sitting between the pipelined datapath and a single lower-level memory (`pmem`). It serves the instruction port (a) and the data port (b) with the same read/write/resp handshake the datapath drives, and serialises their requests onto one `pmem` interface. On contention it grants round-robin, so neither port starves. Each transaction's control, address and write data are latched at grant, and read data is registered before the response pulse.

## Interface
Parameters:
- ADDR_WIDTH, 16, address width on all ports
- DATA_WIDTH, 16, data width on all ports; mask width is DATA_WIDTH/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read_a / mem_write_a  in  1 each  port a request strobes, held until mem_resp_a
- mem_wmask_a  in  DATA_WIDTH/8  port a byte-write mask
- mem_address_a  in  ADDR_WIDTH  port a address
- mem_wdata_a  in  DATA_WIDTH  port a write data
- mem_resp_a  out  1  one-cycle completion pulse for port a
- mem_rdata_a  out  DATA_WIDTH  port a read data, valid while mem_resp_a is high and held until the next port a read completes
- mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b, mem_resp_b, mem_rdata_b  same as port a, for port b
- pmem_read / pmem_write  out  1 each  lower memory request strobes
- pmem_wmask  out  DATA_WIDTH/8  lower memory byte mask
- pmem_address  out  ADDR_WIDTH  lower memory address
- pmem_wdata  out  DATA_WIDTH  lower memory write data
- pmem_resp  in  1  lower memory completion, one-cycle pulse
- pmem_rdata  in  DATA_WIDTH  lower memory read data, valid with pmem_resp

## Operation
- A port requests when its read or write strobe is high. Both strobes high on one port is treated as a write.
- State machine states: IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B.
- IDLE:
  - Only a requesting: go to BUSY_A.
  - Only b requesting: go to BUSY_B.
  - Both requesting: grant the port not recorded in `last_grant`. `last_grant` resets to A, so the first contention goes to B.
  - On the grant edge, latch the op (read/write), address, wmask and wdata of the granted port, and update `last_grant`.
- BUSY_x:
  - pmem_read or pmem_write is driven from the latched op; pmem_address, pmem_wmask and pmem_wdata are driven from the latched registers.
  - Stay in BUSY_x until pmem_resp. On pmem_resp, go to DONE_x.
  - If the latched op is a read, capture pmem_rdata into the rdata_x register on the same edge.
- DONE_x: mem_resp_x = 1 for exactly one cycle, then go to IDLE.
  - The other port's request waits and is evaluated in the IDLE cycle that follows.
- Outside BUSY states: all pmem_* outputs are 0.
- pmem_resp outside BUSY states is ignored.
- Write transactions leave rdata_x unchanged.
- A requester that drops its strobe after grant does not abort the transaction: the pmem transaction completes and mem_resp_x still pulses.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, last_grant = A.
  - All latched registers = 0; rdata_a = rdata_b = 0.
  - mem_resp_a = mem_resp_b = 0, and all pmem_* outputs = 0.
  - Reset in a BUSY state drops pmem_read/pmem_write within the same cycle. A pmem_resp arriving later is ignored.
- Latency:
  - Request visible in IDLE at cycle 0 → pmem strobe at cycle 1.
  - With pmem_resp at cycle k (k ≥ 1), mem_resp_x is at cycle k+1 and IDLE is at k+2.
  - Minimum request-to-resp latency is 2 cycles.
  - Back-to-back transactions from one port are no closer than 3 cycles apart.
- All of mem_resp_x, mem_rdata_x and pmem_* come directly from registers or state decode, with no combinational path from mem_* inputs. Exception: none.
- Requests must be held stable until resp. The arbiter samples them only in IDLE.

## Test plan
- Single read on port a: address 0x1234, pmem_resp 3 cycles after pmem_read, pmem_rdata 0xBEEF → pmem_address 0x1234 from cycle 1; mem_resp_a pulses one cycle after pmem_resp with mem_rdata_a = 0xBEEF; mem_resp_b never asserts.
- Port b write: address 0x0040, wdata 0x00AA, wmask 01, zero-wait pmem (pmem_resp in the first BUSY cycle) → pmem_write=1, pmem_wmask=01, pmem_wdata=0x00AA at cycle 1; mem_resp_b at cycle 2; mem_rdata_b keeps its previous value.
- Simultaneous a-read and b-read out of reset, both held continuously → sequence of grants is B, A, B, A; each resp pulse is one cycle; pmem_read is never high in IDLE/DONE cycles.
- Both strobes high on port a at address 0x0002 → a pmem_write is issued and pmem_read stays 0.
- rst asserted mid-BUSY_B, with pmem_resp arriving 1 cycle later → pmem_write/pmem_read drop asynchronously; no mem_resp_b; after release, a new request on port a is granted normally with last_grant = A behaviour restored.
- pmem_resp glitch while IDLE with no requests → no state change, no resp pulse, rdata registers unchanged.
